// File: rtl/cache_line_responder.sv
// Memory-side responder behind the cache miss/write-back port: serves line and
// word reads as 32-bit beats and commits line or byte-masked word writes.
module cache_line_responder #(
  parameter int WIDTH      = 16,
  parameter int MEM_LINES  = 256,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_req,
  input  logic [2:0]         rd_type,
  input  logic [31:0]        rd_addr,
  output logic               rd_rdy,
  output logic               ret_valid,
  output logic [1:0]         ret_last,
  output logic [31:0]        ret_data,
  input  logic               wr_req,
  input  logic [2:0]         wr_type,
  input  logic [31:0]        wr_addr,
  input  logic [3:0]         wr_wstrb,
  input  logic [WIDTH*8-1:0] wr_wdata,
  output logic               wr_rdy,
  output logic               busy
);

  localparam int WORDS        = WIDTH / 4;
  localparam int OFF_W        = $clog2(WIDTH);
  localparam int WSEL_W       = OFF_W - 2;
  localparam int IDX_W        = $clog2(MEM_LINES);
  localparam int MAX_LAT      = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int LAT_W        = $clog2(MAX_LAT + 1);
  localparam int RD_WAIT_INIT = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BEAT, WR_WAIT} state_t;

  state_t              state_q;
  logic [LAT_W-1:0]    lat_q;
  logic [IDX_W-1:0]    rd_idx_q;
  logic [WSEL_W-1:0]   beat_q;
  logic [WSEL_W-1:0]   left_q;
  logic                ret_valid_q;
  logic                ret_last_q;
  logic [31:0]         ret_data_q;

  logic [IDX_W-1:0]    wr_idx_q;
  logic [WSEL_W-1:0]   wr_wsel_q;
  logic                wr_line_q;
  logic [3:0]          wr_strb_q;
  logic [WIDTH*8-1:0]  wr_data_q;

  // One 32-bit bank per word position so a whole line commits in one edge.
  logic [31:0]         mem_q [WORDS][MEM_LINES];

  logic [IDX_W-1:0]    rd_idx;
  logic [WSEL_W-1:0]   rd_wsel;
  logic [IDX_W-1:0]    wr_idx;
  logic [WSEL_W-1:0]   wr_wsel;
  logic                rd_is_line;
  logic                rd_fire;
  logic                wr_fire;
  logic                wr_commit;
  logic [3:0]          wbe  [WORDS];
  logic [31:0]         wdat [WORDS];
  logic                unused_addr_bits;

  assign rd_idx     = rd_addr[OFF_W +: IDX_W];
  assign rd_wsel    = rd_addr[2 +: WSEL_W];
  assign wr_idx     = wr_addr[OFF_W +: IDX_W];
  assign wr_wsel    = wr_addr[2 +: WSEL_W];
  assign rd_is_line = (rd_type == 3'b100);

  assign unused_addr_bits = ^{rd_addr[31:OFF_W+IDX_W], rd_addr[1:0],
                              wr_addr[31:OFF_W+IDX_W], wr_addr[1:0]};

  // Write wins over a simultaneous read so an eviction lands before its refill.
  assign wr_rdy    = (state_q == IDLE);
  assign rd_rdy    = (state_q == IDLE) && !wr_req;
  assign busy      = (state_q != IDLE);
  assign rd_fire   = rd_req && rd_rdy;
  assign wr_fire   = wr_req && wr_rdy;
  assign wr_commit = (state_q == WR_WAIT) && (lat_q == '0) && !reset;

  assign ret_valid = ret_valid_q;
  assign ret_last  = {1'b0, ret_last_q};
  assign ret_data  = ret_data_q;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign wdat[gi] = wr_line_q ? wr_data_q[gi*32 +: 32] : wr_data_q[31:0];
    assign wbe[gi]  = wr_line_q ? 4'hF :
                      ((wr_wsel_q == WSEL_W'(gi)) ? wr_strb_q : 4'h0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      left_q      <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
    end else begin
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_fire) begin
            state_q <= WR_WAIT;
            lat_q   <= LAT_W'(WR_LATENCY - 1);
          end else if (rd_fire) begin
            state_q <= (RD_LATENCY == 1) ? RD_BEAT : RD_WAIT;
            lat_q   <= LAT_W'(RD_WAIT_INIT);
            beat_q  <= rd_is_line ? '0 : rd_wsel;
            left_q  <= rd_is_line ? WSEL_W'(WORDS - 1) : '0;
          end
        end
        RD_WAIT: begin
          if (lat_q == '0) state_q <= RD_BEAT;
          else             lat_q   <= lat_q - 1'b1;
        end
        RD_BEAT: begin
          ret_valid_q <= 1'b1;
          ret_data_q  <= mem_q[beat_q][rd_idx_q];
          ret_last_q  <= (left_q == '0);
          beat_q      <= beat_q + 1'b1;
          left_q      <= left_q - 1'b1;
          if (left_q == '0) state_q <= IDLE;
        end
        WR_WAIT: begin
          if (lat_q == '0) state_q <= IDLE;
          else             lat_q   <= lat_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request capture needs no reset: it is only consumed after a fresh acceptance.
  always_ff @(posedge clk) begin
    if (rd_fire && !wr_fire) begin
      rd_idx_q <= rd_idx;
    end
    if (wr_fire) begin
      wr_idx_q  <= wr_idx;
      wr_wsel_q <= wr_wsel;
      wr_line_q <= (wr_type == 3'b100);
      wr_strb_q <= wr_wstrb;
      wr_data_q <= wr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int w = 0; w < WORDS; w++) begin
        for (int b = 0; b < 4; b++) begin
          if (wbe[w][b]) mem_q[w][wr_idx_q][b*8 +: 8] <= wdat[w][b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_line_responder.sv
// Randomized and directed bench for cache_line_responder against a flat
// word-array model of the backing store.
module tb_cache_line_responder;

  localparam int WIDTH      = 16;
  localparam int MEM_LINES  = 256;
  localparam int RD_LATENCY = 2;
  localparam int WR_LATENCY = 1;
  localparam int WORDS      = WIDTH / 4;
  localparam int SPAN       = WIDTH * MEM_LINES;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               rd_req = 1'b0;
  logic [2:0]         rd_type = '0;
  logic [31:0]        rd_addr = '0;
  logic               rd_rdy;
  logic               ret_valid;
  logic [1:0]         ret_last;
  logic [31:0]        ret_data;
  logic               wr_req = 1'b0;
  logic [2:0]         wr_type = '0;
  logic [31:0]        wr_addr = '0;
  logic [3:0]         wr_wstrb = '0;
  logic [WIDTH*8-1:0] wr_wdata = '0;
  logic               wr_rdy;
  logic               busy;

  cache_line_responder #(
    .WIDTH(WIDTH), .MEM_LINES(MEM_LINES), .RD_LATENCY(RD_LATENCY), .WR_LATENCY(WR_LATENCY)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_wdata(wr_wdata), .wr_rdy(wr_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [MEM_LINES*WORDS];
  logic [31:0] exp_data [16];
  int          exp_n;
  logic [31:0] cap_data [32];
  logic [1:0]  cap_last [32];
  int          cap_cyc  [32];
  int          cap_n;
  bit          cap_to;

  function automatic int widx(input logic [31:0] a);
    return int'((a % SPAN) / 4);
  endfunction

  task automatic model_write(input logic [2:0] t, input logic [31:0] a,
                             input logic [3:0] s, input logic [WIDTH*8-1:0] d);
    int i;
    i = widx(a);
    if (t == 3'b100) begin
      for (int w = 0; w < WORDS; w++) model_mem[(i & ~(WORDS-1)) + w] = d[w*32 +: 32];
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) model_mem[i][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic model_read(input logic [2:0] t, input logic [31:0] a);
    int i;
    i = widx(a);
    if (t == 3'b100) begin
      exp_n = WORDS;
      for (int w = 0; w < WORDS; w++) exp_data[w] = model_mem[(i & ~(WORDS-1)) + w];
    end else begin
      exp_n = 1;
      exp_data[0] = model_mem[i];
    end
  endtask

  task automatic issue_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                             input logic [WIDTH*8-1:0] d, input bit upd);
    int k = 0;
    @(negedge clk);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_wdata = d;
    #1;
    while (!wr_rdy && k < 50) begin @(negedge clk); #1; k++; end
    checks++;
    if (!wr_rdy) begin
      errors++;
      $display("FAIL wr_accept: wr_rdy=%b after %0d cycles, required 1", wr_rdy, k);
    end else begin
      @(posedge clk); #1;
      if (upd) model_write(t, a, s, d);
      $display("WR  type=%b addr=%h strb=%b data=%h", t, a, s, d);
    end
    wr_req = 1'b0;
  endtask

  task automatic issue_read(input logic [2:0] t, input logic [31:0] a);
    int k = 0;
    @(negedge clk);
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    #1;
    while (!rd_rdy && k < 50) begin @(negedge clk); #1; k++; end
    checks++;
    if (!rd_rdy) begin
      errors++;
      $display("FAIL rd_accept: rd_rdy=%b after %0d cycles, required 1", rd_rdy, k);
    end else begin
      @(posedge clk); #1;
      $display("RD  type=%b addr=%h", t, a);
    end
    rd_req = 1'b0;
  endtask

  // Called just after the acceptance edge; cycle n is the n-th negedge after it.
  task automatic collect_read();
    cap_n  = 0;
    cap_to = 1'b1;
    for (int n = 0; n < RD_LATENCY + WORDS + 8; n++) begin
      @(negedge clk);
      if (ret_valid) begin
        if (cap_n < 32) begin
          cap_data[cap_n] = ret_data; cap_last[cap_n] = ret_last; cap_cyc[cap_n] = n;
        end
        cap_n++;
        if (ret_last[0]) begin cap_to = 1'b0; break; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ret_valid); end
    checks++; if (ret_last !== 2'b00) begin errors++; $display("FAIL reset_last: got %b want 00", ret_last); end
    checks++; if (ret_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", ret_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL reset_rd_rdy: got %b want 1", rd_rdy); end
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL reset_wr_rdy: got %b want 1", wr_rdy); end
  endtask

  task automatic test_fill();
    logic [WIDTH*8-1:0] d;
    for (int l = 0; l < MEM_LINES; l++) begin
      for (int w = 0; w < WORDS; w++) d[w*32 +: 32] = $urandom;
      issue_write(3'b100, 32'(l * WIDTH), 4'h0, d, 1'b1);
    end
  endtask

  task automatic test_line_rw();
    logic [31:0] want [4];
    want = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    issue_write(3'b100, 32'h40, 4'h0, {want[3], want[2], want[1], want[0]}, 1'b1);
    issue_read(3'b100, 32'h48);
    collect_read();
    checks++;
    if (cap_to || cap_n != 4) begin errors++; $display("FAIL line_beats: got %0d want 4", cap_n); end
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      checks++;
      if (cap_data[i] !== want[i] || cap_last[i] !== (i == 3 ? 2'b01 : 2'b00) || cap_cyc[i] != RD_LATENCY + i)
        begin errors++; $display("FAIL line_beat%0d: got %h/%b@%0d want %h/%b@%0d", i, cap_data[i],
              cap_last[i], cap_cyc[i], want[i], (i == 3 ? 2'b01 : 2'b00), RD_LATENCY + i); end
    end
    issue_write(3'b010, 32'h44, 4'b0011, (WIDTH*8)'(32'hAAAA5555), 1'b1);
    issue_read(3'b010, 32'h44);
    collect_read();
    checks++;
    if (cap_to || cap_n != 1 || cap_data[0] !== 32'h22225555 || cap_last[0] !== 2'b01 || cap_cyc[0] != RD_LATENCY)
      begin errors++; $display("FAIL word_masked: got n=%0d %h/%b@%0d want n=1 22225555/01@%0d",
            cap_n, cap_data[0], cap_last[0], cap_cyc[0], RD_LATENCY); end
  endtask

  task automatic test_priority();
    int k = 0;
    @(negedge clk);
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h40;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h40; wr_wdata = {WORDS{32'hDEADBEEF}};
    #1;
    checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL prio_rd_rdy: got %b want 0", rd_rdy); end
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL prio_wr_rdy: got %b want 1", wr_rdy); end
    @(posedge clk); #1;
    wr_req = 1'b0;
    model_write(3'b100, 32'h40, 4'h0, {WORDS{32'hDEADBEEF}});
    $display("WR  type=100 addr=00000040 data=DEADBEEF x%0d (with read pending)", WORDS);
    do begin @(negedge clk); #1; k++; end while (!rd_rdy && k < 50);
    checks++;
    if (k != WR_LATENCY + 1) begin errors++; $display("FAIL prio_rd_wait: read ready after %0d cycles, want %0d", k, WR_LATENCY + 1); end
    @(posedge clk); #1;
    rd_req = 1'b0;
    $display("RD  type=100 addr=00000040 (after write)");
    collect_read();
    checks++;
    if (cap_to || cap_n != WORDS) begin errors++; $display("FAIL prio_beats: got %0d want %0d", cap_n, WORDS); end
    for (int i = 0; i < WORDS && i < cap_n; i++) begin
      checks++;
      if (cap_data[i] !== 32'hDEADBEEF || cap_cyc[i] != RD_LATENCY + i)
        begin errors++; $display("FAIL prio_beat%0d: got %h@%0d want deadbeef@%0d", i, cap_data[i], cap_cyc[i], RD_LATENCY + i); end
    end
  endtask

  // Second read is held pending and must be taken in the first idle cycle,
  // which is the cycle presenting the final beat of the first burst.
  task automatic test_back_to_back();
    logic [31:0] exp_a [16];
    logic [31:0] exp_b [16];
    logic [31:0] addr_a, addr_b;
    int s2, ph;
    bit e_busy, e_valid;
    logic [31:0] e_dat;
    addr_a = 32'h40; addr_b = 32'h1230;
    model_read(3'b100, addr_a); exp_a = exp_data;
    model_read(3'b100, addr_b); exp_b = exp_data;
    s2 = RD_LATENCY + WORDS;
    @(negedge clk);
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = addr_a;
    #1;
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_first_rdy: got %b want 1", rd_rdy); end
    @(posedge clk); #1;
    rd_addr = addr_b;
    $display("RD  type=100 addr=%h then %h held", addr_a, addr_b);
    for (int n = 0; n <= 2 * s2 + 1; n++) begin
      @(negedge clk);
      ph = (n >= s2) ? n - s2 : n;
      e_busy  = (ph <= RD_LATENCY + WORDS - 2);
      e_valid = (ph >= RD_LATENCY) && (ph < RD_LATENCY + WORDS);
      e_dat   = e_valid ? ((n >= s2) ? exp_b[ph - RD_LATENCY] : exp_a[ph - RD_LATENCY]) : 32'h0;
      checks++;
      if (busy !== e_busy || rd_rdy !== !e_busy || ret_valid !== e_valid ||
          ret_last !== ((ph == RD_LATENCY + WORDS - 1) ? 2'b01 : 2'b00))
        begin errors++; $display("FAIL b2b_ctl@%0d: busy/rdy/valid/last got %b/%b/%b/%b want %b/%b/%b/%b", n,
              busy, rd_rdy, ret_valid, ret_last, e_busy, !e_busy, e_valid,
              ((ph == RD_LATENCY + WORDS - 1) ? 2'b01 : 2'b00)); end
      if (e_valid) begin
        checks++;
        if (ret_data !== e_dat) begin errors++; $display("FAIL b2b_data@%0d: got %h want %h", n, ret_data, e_dat); end
      end
      if (n == s2) rd_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_read();
    issue_read(3'b100, 32'h80);
    for (int n = 0; n <= RD_LATENCY + 1; n++) @(negedge clk);
    checks++; if (ret_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_beat2: got valid %b want 1", ret_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ret_valid !== 1'b0 || ret_last !== 2'b00) begin errors++; $display("FAIL rst_mid_out: valid/last %b/%b want 0/00", ret_valid, ret_last); end
    checks++; if (busy !== 1'b0 || rd_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_ctl: busy/rdy %b/%b want 0/1", busy, rd_rdy); end
    for (int n = 0; n < WORDS + 2; n++) begin
      @(negedge clk);
      checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stray@%0d: valid %b want 0", n, ret_valid); end
    end
    model_read(3'b100, 32'h90);
    issue_read(3'b100, 32'h90);
    collect_read();
    checks++;
    if (cap_to || cap_n != exp_n) begin errors++; $display("FAIL rst_mid_next_n: got %0d want %0d", cap_n, exp_n); end
    for (int i = 0; i < exp_n && i < cap_n; i++) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_cyc[i] != RD_LATENCY + i)
        begin errors++; $display("FAIL rst_mid_next%0d: got %h@%0d want %h@%0d", i, cap_data[i], cap_cyc[i], exp_data[i], RD_LATENCY + i); end
    end
  endtask

  task automatic test_reset_wr_wait();
    logic [WIDTH*8-1:0] d;
    for (int w = 0; w < WORDS; w++) d[w*32 +: 32] = $urandom;
    issue_write(3'b100, 32'hC0, 4'h0, d, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_wr_busy: got %b want 0", busy); end
    model_read(3'b100, 32'hC0);
    issue_read(3'b100, 32'hC0);
    collect_read();
    checks++;
    if (cap_to || cap_n != exp_n) begin errors++; $display("FAIL rst_wr_n: got %0d want %0d", cap_n, exp_n); end
    for (int i = 0; i < exp_n && i < cap_n; i++) begin
      checks++;
      if (cap_data[i] !== exp_data[i]) begin errors++; $display("FAIL rst_wr_kept%0d: got %h want %h", i, cap_data[i], exp_data[i]); end
    end
  endtask

  task automatic test_alias();
    logic [WIDTH*8-1:0] d;
    for (int w = 0; w < WORDS; w++) d[w*32 +: 32] = $urandom;
    issue_write(3'b100, 32'h1000, 4'h0, d, 1'b1);
    issue_read(3'b100, 32'h0000);
    collect_read();
    checks++;
    if (cap_to || cap_n != WORDS) begin errors++; $display("FAIL alias_n: got %0d want %0d", cap_n, WORDS); end
    for (int i = 0; i < WORDS && i < cap_n; i++) begin
      checks++;
      if (cap_data[i] !== d[i*32 +: 32]) begin errors++; $display("FAIL alias_beat%0d: got %h want %h", i, cap_data[i], d[i*32 +: 32]); end
    end
  endtask

  task automatic test_random();
    logic [2:0] types [6];
    logic [2:0] t;
    logic [31:0] a, last_a;
    logic [WIDTH*8-1:0] d;
    types  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b111};
    last_a = 32'h0;
    for (int it = 0; it < 80; it++) begin
      t = types[$urandom_range(0, 5)];
      a = ($urandom_range(0, 1) == 0) ? last_a : $urandom;
      if ($urandom_range(0, 1) == 0) begin
        for (int w = 0; w < WORDS; w++) d[w*32 +: 32] = $urandom;
        issue_write(t, a, 4'($urandom_range(0, 15)), d, 1'b1);
      end else begin
        model_read(t, a);
        issue_read(t, a);
        collect_read();
        checks++;
        if (cap_to || cap_n != exp_n) begin errors++; $display("FAIL rand%0d_n: got %0d want %0d", it, cap_n, exp_n); end
        for (int i = 0; i < exp_n && i < cap_n; i++) begin
          checks++;
          if (cap_data[i] !== exp_data[i] || cap_last[i] !== (i == exp_n - 1 ? 2'b01 : 2'b00) ||
              cap_cyc[i] != RD_LATENCY + i)
            begin errors++; $display("FAIL rand%0d_beat%0d: got %h/%b@%0d want %h/%b@%0d", it, i, cap_data[i],
                  cap_last[i], cap_cyc[i], exp_data[i], (i == exp_n - 1 ? 2'b01 : 2'b00), RD_LATENCY + i); end
        end
      end
      last_a = a;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_line_rw();
    test_priority();
    test_back_to_back();
    test_reset_mid_read();
    test_reset_wr_wait();
    test_alias();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
